// File: rtl/exec_ctrl.sv
// Execute-stage controller: in-order micro-op queue issuing to an ALU and a CMP flag unit,
// with a registered writeback stage and the architectural EFLAGS register.

`ifndef REG_W
`define REG_W 64
`endif
`ifndef OPCODE_W
`define OPCODE_W 4
`endif
`ifndef IMM_W
`define IMM_W 32
`endif
`ifndef DISP_W
`define DISP_W 32
`endif
`ifndef BIT_MODE_W
`define BIT_MODE_W 2
`endif

`ifndef MICRO_ADD
`define MICRO_ADD  1
`define MICRO_ADDI 2
`define MICRO_SLLI 3
`define MICRO_XOR  4
`define MICRO_MOV  5
`define MICRO_MOVI 6
`define MICRO_LEA  7
`define MICRO_CMP  8
`endif

module exec_ctrl #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [`OPCODE_W-1:0]   in_opcode,
    input  logic [`REG_W-1:0]      in_s,
    input  logic [`REG_W-1:0]      in_t,
    input  logic [`IMM_W-1:0]      in_imm,
    input  logic [`DISP_W-1:0]     in_disp,
    input  logic [`BIT_MODE_W-1:0] in_bit_mode,
    input  logic [3:0]             in_dst,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic                   wb_we,
    output logic [3:0]             wb_dst,
    output logic [`REG_W-1:0]      wb_data,
    output logic                   wb_illegal,
    output logic [`REG_W-1:0]      eflags,
    output logic                   busy
);
    localparam int unsigned REG_W      = `REG_W;
    localparam int unsigned OPCODE_W   = `OPCODE_W;
    localparam int unsigned IMM_W      = `IMM_W;
    localparam int unsigned DISP_W     = `DISP_W;
    localparam int unsigned BIT_MODE_W = `BIT_MODE_W;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(`MICRO_ADD);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(`MICRO_ADDI);
    localparam logic [OPCODE_W-1:0] OP_SLLI = OPCODE_W'(`MICRO_SLLI);
    localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(`MICRO_XOR);
    localparam logic [OPCODE_W-1:0] OP_MOV  = OPCODE_W'(`MICRO_MOV);
    localparam logic [OPCODE_W-1:0] OP_MOVI = OPCODE_W'(`MICRO_MOVI);
    localparam logic [OPCODE_W-1:0] OP_LEA  = OPCODE_W'(`MICRO_LEA);
    localparam logic [OPCODE_W-1:0] OP_CMP  = OPCODE_W'(`MICRO_CMP);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_HELD  = 1'b1;

    localparam int unsigned CF_BIT = 0;
    localparam int unsigned PF_BIT = 2;
    localparam int unsigned ZF_BIT = 6;
    localparam int unsigned SF_BIT = 7;
    localparam int unsigned OF_BIT = 11;

    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [REG_W-1:0]      s;
        logic [REG_W-1:0]      t;
        logic [IMM_W-1:0]      imm;
        logic [DISP_W-1:0]     disp;
        logic [BIT_MODE_W-1:0] bit_mode;
        logic [3:0]            dst;
    } uop_t;

    uop_t                  mem_q [FIFO_DEPTH];
    uop_t                  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  state_q, state_d;
    logic                  wb_we_q, wb_we_d;
    logic [3:0]            wb_dst_q, wb_dst_d;
    logic [REG_W-1:0]      wb_data_q, wb_data_d;
    logic                  wb_illegal_q, wb_illegal_d;
    logic [REG_W-1:0]      eflags_q, eflags_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;

    uop_t                  head_c;
    logic                  push_c, issue_c;
    logic                  head_writes_c;
    logic [REG_W-1:0]      alu_t_c, alu_d_c;
    logic                  cmp_cf_c, cmp_pf_c, cmp_zf_c, cmp_sf_c, cmp_of_c;

    // Issue operand formation from the queue head
    always_comb begin
        head_c = mem_q[rd_ptr_q];
        case (head_c.opcode)
            OP_ADDI, OP_SLLI, OP_MOVI: alu_t_c = REG_W'($signed(head_c.imm));
            default:                   alu_t_c = head_c.t;
        endcase
        case (head_c.opcode)
            OP_ADD, OP_ADDI, OP_SLLI, OP_XOR,
            OP_MOV, OP_MOVI, OP_LEA:   head_writes_c = 1'b1;
            default:                   head_writes_c = 1'b0;
        endcase
    end

    alu u_alu (
        .op       (head_c.opcode),
        .s        (head_c.s),
        .t        (alu_t_c),
        .disp     (head_c.disp),
        .bit_mode (head_c.bit_mode),
        .d        (alu_d_c)
    );

    execute_cmp u_cmp (
        .s        (head_c.s),
        .t        (head_c.t),
        .bit_mode (head_c.bit_mode),
        .cf       (cmp_cf_c),
        .pf       (cmp_pf_c),
        .zf       (cmp_zf_c),
        .sf       (cmp_sf_c),
        .of       (cmp_of_c)
    );

    assign push_c  = in_valid && in_ready_q && !flush;
    assign issue_c = (count_q != '0) && ((state_q == ST_EMPTY) || wb_ready) && !flush;

    // Queue, result stage and EFLAGS next-state
    always_comb begin
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        state_d      = state_q;
        wb_we_d      = wb_we_q;
        wb_dst_d     = wb_dst_q;
        wb_data_d    = wb_data_q;
        wb_illegal_d = wb_illegal_q;
        eflags_d     = eflags_q;

        if (push_c) begin
            mem_d[wr_ptr_q] = '{opcode: in_opcode, s: in_s, t: in_t, imm: in_imm,
                                disp: in_disp, bit_mode: in_bit_mode, dst: in_dst};
            wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
        end
        if (issue_c) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        end
        case ({push_c, issue_c})
            2'b10:   count_d = CNT_W'(count_q + 1'b1);
            2'b01:   count_d = CNT_W'(count_q - 1'b1);
            default: count_d = count_q;
        endcase

        if (issue_c) begin
            state_d      = ST_HELD;
            wb_dst_d     = head_c.dst;
            wb_we_d      = head_writes_c;
            wb_data_d    = head_writes_c ? alu_d_c : '0;
            wb_illegal_d = !head_writes_c && (head_c.opcode != OP_CMP);
            if (head_c.opcode == OP_CMP) begin
                eflags_d[CF_BIT] = cmp_cf_c;
                eflags_d[PF_BIT] = cmp_pf_c;
                eflags_d[ZF_BIT] = cmp_zf_c;
                eflags_d[SF_BIT] = cmp_sf_c;
                eflags_d[OF_BIT] = cmp_of_c;
            end
        end else if ((state_q == ST_HELD) && wb_ready) begin
            state_d      = ST_EMPTY;
            wb_we_d      = 1'b0;
            wb_dst_d     = '0;
            wb_data_d    = '0;
            wb_illegal_d = 1'b0;
        end

        if (flush) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            state_d      = ST_EMPTY;
            wb_we_d      = 1'b0;
            wb_dst_d     = '0;
            wb_data_d    = '0;
            wb_illegal_d = 1'b0;
        end

        in_ready_d = (count_d < CNT_W'(FIFO_DEPTH));
        busy_d     = (count_d != '0) || (state_d == ST_HELD);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_EMPTY;
            wb_we_q      <= 1'b0;
            wb_dst_q     <= '0;
            wb_data_q    <= '0;
            wb_illegal_q <= 1'b0;
            eflags_q     <= REG_W'(2);
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            wb_we_q      <= wb_we_d;
            wb_dst_q     <= wb_dst_d;
            wb_data_q    <= wb_data_d;
            wb_illegal_q <= wb_illegal_d;
            eflags_q     <= eflags_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign in_ready   = in_ready_q;
    assign wb_valid   = (state_q == ST_HELD);
    assign wb_we      = wb_we_q;
    assign wb_dst     = wb_dst_q;
    assign wb_data    = wb_data_q;
    assign wb_illegal = wb_illegal_q;
    assign eflags     = eflags_q;
    assign busy       = busy_q;

endmodule

// Integer ALU; results are truncated to the operand size and sign-extended to REG_W.
module alu (
    input  logic [`OPCODE_W-1:0]   op,
    input  logic [`REG_W-1:0]      s,
    input  logic [`REG_W-1:0]      t,
    input  logic [`DISP_W-1:0]     disp,
    input  logic [`BIT_MODE_W-1:0] bit_mode,
    output logic [`REG_W-1:0]      d
);
    localparam int unsigned REG_W      = `REG_W;
    localparam int unsigned OPCODE_W   = `OPCODE_W;
    localparam int unsigned BIT_MODE_W = `BIT_MODE_W;
    localparam int unsigned SHAMT_W    = $clog2(REG_W);

    function automatic logic [REG_W-1:0] size_ext(input logic [REG_W-1:0] x,
                                                  input logic [BIT_MODE_W-1:0] m);
        logic [REG_W-1:0] r;
        case (m)
            BIT_MODE_W'(0): r = {{(REG_W-8){x[7]}}, x[7:0]};
            BIT_MODE_W'(1): r = {{(REG_W-16){x[15]}}, x[15:0]};
            BIT_MODE_W'(2): r = {{(REG_W-32){x[31]}}, x[31:0]};
            default:        r = x;
        endcase
        return r;
    endfunction

    logic [REG_W-1:0] raw_c;

    always_comb begin
        raw_c = '0;
        case (op)
            OPCODE_W'(`MICRO_ADD), OPCODE_W'(`MICRO_ADDI): raw_c = s + t;
            OPCODE_W'(`MICRO_SLLI):                        raw_c = s << t[SHAMT_W-1:0];
            OPCODE_W'(`MICRO_XOR):                         raw_c = s ^ t;
            OPCODE_W'(`MICRO_MOV), OPCODE_W'(`MICRO_MOVI): raw_c = t;
            OPCODE_W'(`MICRO_LEA):                         raw_c = s + t + REG_W'($signed(disp));
            OPCODE_W'(`MICRO_CMP):                         raw_c = s - t;
            default:                                       raw_c = '0;
        endcase
        d = size_ext(raw_c, bit_mode);
    end

endmodule

// Flag generation for CMP (s - t) at the selected operand size.
module execute_cmp (
    input  logic [`REG_W-1:0]      s,
    input  logic [`REG_W-1:0]      t,
    input  logic [`BIT_MODE_W-1:0] bit_mode,
    output logic                   cf,
    output logic                   pf,
    output logic                   zf,
    output logic                   sf,
    output logic                   of
);
    localparam int unsigned REG_W      = `REG_W;
    localparam int unsigned BIT_MODE_W = `BIT_MODE_W;

    function automatic logic [REG_W-1:0] size_ext(input logic [REG_W-1:0] x,
                                                  input logic [BIT_MODE_W-1:0] m,
                                                  input logic sgn);
        logic [REG_W-1:0] r;
        case (m)
            BIT_MODE_W'(0): r = {{(REG_W-8){sgn & x[7]}}, x[7:0]};
            BIT_MODE_W'(1): r = {{(REG_W-16){sgn & x[15]}}, x[15:0]};
            BIT_MODE_W'(2): r = {{(REG_W-32){sgn & x[31]}}, x[31:0]};
            default:        r = x;
        endcase
        return r;
    endfunction

    logic [REG_W-1:0] s_sx_c, t_sx_c, diff_c;

    always_comb begin
        s_sx_c = size_ext(s, bit_mode, 1'b1);
        t_sx_c = size_ext(t, bit_mode, 1'b1);
        diff_c = size_ext(s - t, bit_mode, 1'b1);
        cf     = size_ext(s, bit_mode, 1'b0) < size_ext(t, bit_mode, 1'b0);
        zf     = (diff_c == '0);
        sf     = diff_c[REG_W-1];
        pf     = ~^diff_c[7:0];
        // Signed overflow: operand signs differ and the result sign differs from s
        of     = (s_sx_c[REG_W-1] != t_sx_c[REG_W-1]) && (diff_c[REG_W-1] != s_sx_c[REG_W-1]);
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed self-checking bench for exec_ctrl: datapath results, EFLAGS, backpressure,
// flush and reset behaviour with hand-computed expectations.
module tb_exec_ctrl;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SLLI = 4'h3;
    localparam logic [3:0] OP_CMP  = 4'h8;
    localparam logic [3:0] OP_BAD  = 4'hF;

    logic        clk = 1'b0;
    logic        rstn, flush, in_valid, in_ready;
    logic [3:0]  in_opcode;
    logic [63:0] in_s, in_t;
    logic [31:0] in_imm, in_disp;
    logic [1:0]  in_bit_mode;
    logic [3:0]  in_dst;
    logic        wb_valid, wb_ready, wb_we, wb_illegal, busy;
    logic [3:0]  wb_dst;
    logic [63:0] wb_data, eflags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exec_ctrl #(.FIFO_DEPTH(2)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_s(in_s), .in_t(in_t), .in_imm(in_imm), .in_disp(in_disp),
        .in_bit_mode(in_bit_mode), .in_dst(in_dst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_dst(wb_dst),
        .wb_data(wb_data), .wb_illegal(wb_illegal), .eflags(eflags), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [63:0] s, input logic [63:0] t,
                         input logic [31:0] imm, input logic [1:0] mode, input logic [3:0] dst);
        in_valid    = 1'b1;
        in_opcode   = op;
        in_s        = s;
        in_t        = t;
        in_imm      = imm;
        in_disp     = 32'd0;
        in_bit_mode = mode;
        in_dst      = dst;
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
        drive(4'h0, 64'd0, 64'd0, 32'd0, 2'd0, 4'd0);
        in_valid = 1'b0;
        step(); step();
        n_checks++; if (wb_valid !== 1'b0) begin $display("FAIL rst_wb_valid got %b want 0", wb_valid); n_fail++; end
        n_checks++; if (wb_we !== 1'b0) begin $display("FAIL rst_wb_we got %b want 0", wb_we); n_fail++; end
        n_checks++; if (wb_dst !== 4'd0) begin $display("FAIL rst_wb_dst got %h want 0", wb_dst); n_fail++; end
        n_checks++; if (wb_data !== 64'd0) begin $display("FAIL rst_wb_data got %h want 0", wb_data); n_fail++; end
        n_checks++; if (wb_illegal !== 1'b0) begin $display("FAIL rst_wb_illegal got %b want 0", wb_illegal); n_fail++; end
        n_checks++; if (busy !== 1'b0) begin $display("FAIL rst_busy got %b want 0", busy); n_fail++; end
        n_checks++; if (eflags !== 64'h2) begin $display("FAIL rst_eflags got %h want 2", eflags); n_fail++; end
        n_checks++; if (in_ready !== 1'b0) begin $display("FAIL rst_in_ready got %b want 0", in_ready); n_fail++; end
        rstn = 1'b1;
        step();
        n_checks++; if (in_ready !== 1'b1) begin $display("FAIL rst_release_in_ready got %b want 1", in_ready); n_fail++; end
    endtask

    task automatic test_add();
        wb_ready = 1'b1;
        drive(OP_ADD, 64'd5, 64'd7, 32'd0, 2'd3, 4'd3);
        step();
        in_valid = 1'b0;
        n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b1) begin $display("FAIL add_queued got valid=%b busy=%b want 0/1", wb_valid, busy); n_fail++; end
        step();
        n_checks++; if (wb_valid !== 1'b1) begin $display("FAIL add_wb_valid got %b want 1", wb_valid); n_fail++; end
        n_checks++; if (wb_data !== 64'd12) begin $display("FAIL add_wb_data got %h want c", wb_data); n_fail++; end
        n_checks++; if (wb_we !== 1'b1 || wb_dst !== 4'd3 || wb_illegal !== 1'b0) begin $display("FAIL add_wb_ctl got we=%b dst=%h ill=%b want 1/3/0", wb_we, wb_dst, wb_illegal); n_fail++; end
        step();
        n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || wb_we !== 1'b0) begin $display("FAIL add_drain got valid=%b busy=%b we=%b want 0/0/0", wb_valid, busy, wb_we); n_fail++; end
    endtask

    task automatic test_addi_slli();
        wb_ready = 1'b1;
        drive(OP_ADDI, 64'h7FFF_FFFF, 64'd0, 32'd1, 2'd2, 4'd1);
        step();
        drive(OP_SLLI, 64'h81, 64'd0, 32'd1, 2'd0, 4'd5);
        step();
        in_valid = 1'b0;
        n_checks++; if (wb_valid !== 1'b1 || wb_data !== 64'hFFFF_FFFF_8000_0000 || wb_dst !== 4'd1) begin $display("FAIL addi_result got v=%b data=%h dst=%h want 1/ffffffff80000000/1", wb_valid, wb_data, wb_dst); n_fail++; end
        step();
        n_checks++; if (wb_valid !== 1'b1 || wb_data !== 64'h02 || wb_dst !== 4'd5) begin $display("FAIL slli_result got v=%b data=%h dst=%h want 1/2/5", wb_valid, wb_data, wb_dst); n_fail++; end
        step();
        n_checks++; if (wb_valid !== 1'b0) begin $display("FAIL addi_slli_drain got %b want 0", wb_valid); n_fail++; end
    endtask

    task automatic test_cmp();
        wb_ready = 1'b1;
        drive(OP_CMP, 64'd9, 64'd9, 32'd0, 2'd3, 4'd2);
        step();
        drive(OP_ADD, 64'd1, 64'd2, 32'd0, 2'd3, 4'd7);
        step();
        in_valid = 1'b0;
        n_checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_data !== 64'd0 || wb_illegal !== 1'b0) begin $display("FAIL cmp_wb got v=%b we=%b data=%h ill=%b want 1/0/0/0", wb_valid, wb_we, wb_data, wb_illegal); n_fail++; end
        n_checks++; if (eflags !== 64'h46) begin $display("FAIL cmp_eflags got %h want 46", eflags); n_fail++; end
        step();
        n_checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_data !== 64'd3 || wb_dst !== 4'd7) begin $display("FAIL cmp_next_add got v=%b we=%b data=%h dst=%h want 1/1/3/7", wb_valid, wb_we, wb_data, wb_dst); n_fail++; end
        n_checks++; if (eflags !== 64'h46) begin $display("FAIL cmp_eflags_stable got %h want 46", eflags); n_fail++; end
        step();
    endtask

    task automatic test_back_to_back();
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(OP_ADD, 64'(100 + i), 64'(i), 32'd0, 2'd3, 4'(i));
            step();
        end
        drive(OP_ADD, 64'd103, 64'd3, 32'd0, 2'd3, 4'd3);
        step();
        n_checks++; if (in_ready !== 1'b0) begin $display("FAIL bp_full_in_ready got %b want 0", in_ready); n_fail++; end
        n_checks++; if (wb_valid !== 1'b1 || wb_data !== 64'd100 || wb_dst !== 4'd0) begin $display("FAIL bp_hold got v=%b data=%h dst=%h want 1/64/0", wb_valid, wb_data, wb_dst); n_fail++; end
        step();
        n_checks++; if (wb_data !== 64'd100 || in_ready !== 1'b0) begin $display("FAIL bp_stable got data=%h rdy=%b want 64/0", wb_data, in_ready); n_fail++; end
        wb_ready = 1'b1;
        step();
        n_checks++; if (wb_data !== 64'd102 || wb_dst !== 4'd1 || in_ready !== 1'b1) begin $display("FAIL bp_rel1 got data=%h dst=%h rdy=%b want 66/1/1", wb_data, wb_dst, in_ready); n_fail++; end
        step();
        in_valid = 1'b0;
        n_checks++; if (wb_data !== 64'd104 || wb_dst !== 4'd2) begin $display("FAIL bp_rel2 got data=%h dst=%h want 68/2", wb_data, wb_dst); n_fail++; end
        step();
        n_checks++; if (wb_valid !== 1'b1 || wb_data !== 64'd106 || wb_dst !== 4'd3) begin $display("FAIL bp_rel3 got v=%b data=%h dst=%h want 1/6a/3", wb_valid, wb_data, wb_dst); n_fail++; end
        step();
        n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL bp_drain got v=%b busy=%b rdy=%b want 0/0/1", wb_valid, busy, in_ready); n_fail++; end
    endtask

    task automatic test_flush();
        wb_ready = 1'b0;
        drive(OP_ADD, 64'd1, 64'd1, 32'd0, 2'd3, 4'd4);
        step();
        drive(OP_CMP, 64'd1, 64'd2, 32'd0, 2'd3, 4'd0);
        step();
        in_valid = 1'b0;
        n_checks++; if (wb_valid !== 1'b1 || wb_data !== 64'd2) begin $display("FAIL flush_pre got v=%b data=%h want 1/2", wb_valid, wb_data); n_fail++; end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || wb_we !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL flush_clear got v=%b busy=%b we=%b rdy=%b want 0/0/0/1", wb_valid, busy, wb_we, in_ready); n_fail++; end
        wb_ready = 1'b1;
        step();
        n_checks++; if (wb_valid !== 1'b0 || eflags !== 64'h46) begin $display("FAIL flush_cmp_dropped got v=%b eflags=%h want 0/46", wb_valid, eflags); n_fail++; end
    endtask

    task automatic test_cmp_less();
        wb_ready = 1'b1;
        drive(OP_CMP, 64'd1, 64'd2, 32'd0, 2'd3, 4'd0);
        step();
        in_valid = 1'b0;
        step();
        n_checks++; if (eflags !== 64'h87) begin $display("FAIL cmp_less_eflags got %h want 87", eflags); n_fail++; end
        step();
    endtask

    task automatic test_illegal();
        wb_ready = 1'b1;
        drive(OP_BAD, 64'd3, 64'd4, 32'd0, 2'd3, 4'd9);
        step();
        in_valid = 1'b0;
        step();
        n_checks++; if (wb_valid !== 1'b1 || wb_illegal !== 1'b1 || wb_we !== 1'b0 || wb_data !== 64'd0) begin $display("FAIL illegal_wb got v=%b ill=%b we=%b data=%h want 1/1/0/0", wb_valid, wb_illegal, wb_we, wb_data); n_fail++; end
        n_checks++; if (eflags !== 64'h87) begin $display("FAIL illegal_eflags got %h want 87", eflags); n_fail++; end
        step();
        n_checks++; if (wb_valid !== 1'b0 || wb_illegal !== 1'b0) begin $display("FAIL illegal_drain got v=%b ill=%b want 0/0", wb_valid, wb_illegal); n_fail++; end
    endtask

    task automatic test_reset_midstream();
        wb_ready = 1'b0;
        drive(OP_ADD, 64'd8, 64'd8, 32'd0, 2'd3, 4'd6);
        step();
        drive(OP_ADD, 64'd9, 64'd9, 32'd0, 2'd3, 4'd7);
        step();
        in_valid = 1'b0;
        rstn = 1'b0;
        step();
        n_checks++; if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_dst !== 4'd0 || wb_data !== 64'd0 || wb_illegal !== 1'b0) begin $display("FAIL mid_rst_wb got v=%b we=%b dst=%h data=%h ill=%b want all 0", wb_valid, wb_we, wb_dst, wb_data, wb_illegal); n_fail++; end
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || eflags !== 64'h2) begin $display("FAIL mid_rst_ctl got busy=%b rdy=%b eflags=%h want 0/0/2", busy, in_ready, eflags); n_fail++; end
        rstn = 1'b1;
        wb_ready = 1'b1;
        step();
        step();
        n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL mid_rst_after got v=%b busy=%b rdy=%b want 0/0/1", wb_valid, busy, in_ready); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi_slli();
        test_cmp();
        test_back_to_back();
        test_flush();
        test_cmp_less();
        test_illegal();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
